// File: rtl/clock_set_pkg.sv
// Shared types and constants for the HH:MM:SS time-setting controller.
// Contents: controller state enum, field_sel encodings, BCD digit and
// two-digit field types, the packed HH:MM:SS payload, field limits,
// digit index constants for the 24-bit packing, and capture helpers.
package clock_set_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_EDIT_HR  = 3'd1,
    ST_EDIT_MIN = 3'd2,
    ST_EDIT_SEC = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  localparam logic [1:0] FSEL_NONE = 2'd0;
  localparam logic [1:0] FSEL_HR   = 2'd1;
  localparam logic [1:0] FSEL_MIN  = 2'd2;
  localparam logic [1:0] FSEL_SEC  = 2'd3;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  // Same packing as cur_digits / set_value: {h10,h1,m10,m1,s10,s1}
  typedef struct packed {
    bcd2_t hr;
    bcd2_t min;
    bcd2_t sec;
  } hms_t;

  localparam bcd2_t HR_MAX = 8'h23;
  localparam bcd2_t MS_MAX = 8'h59;

  // Digit positions (x4 gives the bit offset) inside the 24-bit packing
  localparam int unsigned DIG_S1     = 0;
  localparam int unsigned DIG_S10    = 1;
  localparam int unsigned DIG_M1     = 2;
  localparam int unsigned DIG_M10    = 3;
  localparam int unsigned DIG_H1     = 4;
  localparam int unsigned DIG_H10    = 5;
  localparam int unsigned NUM_DIGITS = DIG_H10 + 1;

  // Any non-BCD ones digit or out-of-range value loads as 00. With a valid
  // ones digit, packed BCD compares like the numeric value, and a bad tens
  // digit always exceeds max.
  function automatic bcd2_t bcd2_sanitize(input bcd2_t v, input bcd2_t max);
    if ((v.ones > 4'd9) || (v > max)) return bcd2_t'(8'h00);
    return v;
  endfunction

  function automatic logic is_edit(input state_t s);
    return (s == ST_EDIT_HR) || (s == ST_EDIT_MIN) || (s == ST_EDIT_SEC);
  endfunction

endpackage

// File: rtl/bcd2_wrap_inc.sv
// Combinational two-digit BCD incrementer that wraps MAX back to 00.
// Ports:
//   value  - current two-digit BCD field
//   result - value + 1, with 9->0 ones carry into tens, MAX -> 00
module bcd2_wrap_inc
  import clock_set_pkg::*;
#(
  parameter bcd2_t MAX = MS_MAX
) (
  input  bcd2_t value,
  output bcd2_t result
);

  always_comb begin
    result = value;
    if (value == MAX) begin
      result = bcd2_t'(8'h00);
    end else if (value.ones == 4'd9) begin
      result.tens = value.tens + 4'd1;
      result.ones = 4'd0;
    end else begin
      result.ones = value.ones + 4'd1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the HH:MM:SS digit counter chain.
// RUN enables counting; edit states freeze the chain and step the selected
// field in a shadow copy; COMMIT loads all six digit counters for one cycle.
// Optional macro CLOCK_SET_BLINK_EN: divided blink of the selected field;
// without it blink is simply high in every edit state.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   mode_btn    - pulse: enter edit / next field / commit
//   inc_btn     - pulse: increment selected field
//   cur_digits  - live counter digits {h10,h1,m10,m1,s10,s1}
//   run_en      - count enable to the chain
//   set_pulse   - per-digit load strobe (COMMIT only)
//   set_value   - load values, held between commits
//   field_sel   - 0 none, 1 hours, 2 minutes, 3 seconds
//   blink       - blanking hint for the selected field
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned BLINK_DIV      = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic [23:0] cur_digits,
  output logic        run_en,
  output logic [5:0]  set_pulse,
  output logic [23:0] set_value,
  output logic [1:0]  field_sel,
  output logic        blink
);

  localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, next_state;
  hms_t          shadow;
  hms_t          cur;
  bcd2_t         hr_inc, min_inc, sec_inc;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          inc_only;

  assign cur      = hms_t'(cur_digits);
  // Mode wins over a simultaneous increment
  assign inc_only = inc_btn & ~mode_btn;
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  bcd2_wrap_inc #(.MAX(HR_MAX)) u_hr_inc  (.value(shadow.hr),  .result(hr_inc));
  bcd2_wrap_inc #(.MAX(MS_MAX)) u_min_inc (.value(shadow.min), .result(min_inc));
  bcd2_wrap_inc #(.MAX(MS_MAX)) u_sec_inc (.value(shadow.sec), .result(sec_inc));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= next_state;
  end

  // Next-state logic; an idle timeout abandons the edit without loading
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (mode_btn) next_state = ST_EDIT_HR;
      end
      ST_EDIT_HR: begin
        if (mode_btn)                 next_state = ST_EDIT_MIN;
        else if (!inc_btn && tmo_hit) next_state = ST_RUN;
      end
      ST_EDIT_MIN: begin
        if (mode_btn)                 next_state = ST_EDIT_SEC;
        else if (!inc_btn && tmo_hit) next_state = ST_RUN;
      end
      ST_EDIT_SEC: begin
        if (mode_btn)                 next_state = ST_COMMIT;
        else if (!inc_btn && tmo_hit) next_state = ST_RUN;
      end
      ST_COMMIT: next_state = ST_RUN;
      default:   next_state = ST_RUN;
    endcase
  end

`ifdef CLOCK_SET_BLINK_EN
  localparam int unsigned BDW = (BLINK_DIV <= 1) ? 1 : $clog2(BLINK_DIV);

  logic [BDW-1:0] blink_cnt;
  logic           blink_q;

  // Blink divider restarts high on every edit-state entry, idle low outside edit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (!is_edit(next_state)) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (next_state != state) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == BDW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + BDW'(1);
    end
  end
`else
  // No divider in this build; the parameter only keeps the interface uniform
  if (BLINK_DIV == 0) begin : g_blink_div_unused
  end
`endif

  // Moore outputs decoded from the state register
  always_comb begin
    run_en    = 1'b0;
    field_sel = FSEL_NONE;
    set_pulse = '0;
    blink     = 1'b0;
    case (state)
      ST_RUN:      run_en    = 1'b1;
      ST_EDIT_HR:  field_sel = FSEL_HR;
      ST_EDIT_MIN: field_sel = FSEL_MIN;
      ST_EDIT_SEC: field_sel = FSEL_SEC;
      ST_COMMIT:   set_pulse = {NUM_DIGITS{1'b1}};
      default:     run_en    = 1'b1;
    endcase
`ifdef CLOCK_SET_BLINK_EN
    blink = blink_q;
`else
    blink = is_edit(state);
`endif
  end

  // Shadow time: sanitised capture on entry, per-field wrap increments in edit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if ((state == ST_RUN) && mode_btn) begin
      shadow.hr  <= bcd2_sanitize(cur.hr,  HR_MAX);
      shadow.min <= bcd2_sanitize(cur.min, MS_MAX);
      shadow.sec <= bcd2_sanitize(cur.sec, MS_MAX);
    end else if (inc_only) begin
      case (state)
        ST_EDIT_HR:  shadow.hr  <= hr_inc;
        ST_EDIT_MIN: shadow.min <= min_inc;
        ST_EDIT_SEC: shadow.sec <= sec_inc;
        default: ;
      endcase
    end
  end

  // Load value is registered on the edge into COMMIT and then held
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       set_value <= '0;
    else if (next_state == ST_COMMIT) set_value <= shadow;
  end

  // Idle counter: cleared outside edit, on field change and on any button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (!is_edit(state) || mode_btn || inc_btn) begin
      tmo_cnt <= '0;
    end else if ((TIMEOUT_CYCLES != 0) && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: reset checks, a vector table for
// edit/commit/wrap/sanitise cases, hand sequences for timeout and mid-edit
// reset, then random buttons and digits against a field-level time model.
module tb_clock_set_ctrl;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode_btn = 1'b0;
  logic        inc_btn = 1'b0;
  logic [23:0] cur_digits = 24'h0;
  logic        run_en;
  logic [5:0]  set_pulse;
  logic [23:0] set_value;
  logic [1:0]  field_sel;
  logic        blink;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(.TIMEOUT_CYCLES(TMO), .BLINK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_btn   (mode_btn),
    .inc_btn    (inc_btn),
    .cur_digits (cur_digits),
    .run_en     (run_en),
    .set_pulse  (set_pulse),
    .set_value  (set_value),
    .field_sel  (field_sel),
    .blink      (blink)
  );

  typedef struct {
    logic        m;
    logic        i;
    logic [23:0] d;
    logic        r;
    logic [1:0]  f;
    logic [5:0]  p;
    logic [23:0] sv;
  } vec_t;

  vec_t vecs[$];

  // Expected observation; blink is only predictable without the divider
  function automatic logic [63:0] expect_obs(input logic r, input logic [1:0] f,
                                             input logic [5:0] p, input logic [23:0] sv);
    logic b;
`ifdef CLOCK_SET_BLINK_EN
    b = 1'b0;
`else
    b = (f != 2'd0);
`endif
    return {30'b0, b, r, f, p, sv};
  endfunction

  function automatic logic [63:0] observed();
    logic b;
`ifdef CLOCK_SET_BLINK_EN
    b = 1'b0;
`else
    b = blink;
`endif
    return {30'b0, b, run_en, field_sel, set_pulse, set_value};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step(input logic m, input logic i, input logic [23:0] d);
    mode_btn   = m;
    inc_btn    = i;
    cur_digits = d;
    @(posedge clk);
    #1;
  endtask

  task automatic vadd(input logic m, input logic i, input logic [23:0] d, input logic r,
                      input logic [1:0] f, input logic [5:0] p, input logic [23:0] sv);
    vec_t v;
    v.m = m; v.i = i; v.d = d; v.r = r; v.f = f; v.p = p; v.sv = sv;
    vecs.push_back(v);
  endtask

  // ---------------- reference model (time fields as integers) ----------------
  int          ph;      // 0 run, 1 hours, 2 minutes, 3 seconds, 4 commit
  int          m_hr, m_min, m_sec, idle;
  logic [23:0] m_sv;

  function automatic int fval(input logic [7:0] f, input int lim);
    int t, o, v;
    t = int'(f[7:4]);
    o = int'(f[3:0]);
    v = t * 10 + o;
    if (t > 9 || o > 9 || v > lim) return 0;
    return v;
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input logic m, input logic i, input logic [23:0] d);
    if (ph == 0) begin
      if (m) begin
        ph = 1; idle = 0;
        m_hr = fval(d[23:16], 23); m_min = fval(d[15:8], 59); m_sec = fval(d[7:0], 59);
      end
    end else if (ph == 4) begin
      ph = 0;
    end else if (m) begin
      ph = ph + 1; idle = 0;
      if (ph == 4) m_sv = {to_bcd2(m_hr), to_bcd2(m_min), to_bcd2(m_sec)};
    end else if (i) begin
      idle = 0;
      if (ph == 1) m_hr = (m_hr + 1) % 24;
      else if (ph == 2) m_min = (m_min + 1) % 60;
      else m_sec = (m_sec + 1) % 60;
    end else if (idle >= TMO) begin
      ph = 0;
    end else begin
      idle++;
    end
  endtask

  function automatic logic [23:0] rand_digits();
    logic [23:0] d;
    for (int k = 0; k < 6; k++)
      d[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    if ($urandom_range(0, 3) != 0) d[23:20] = 4'($urandom_range(0, 2));
    return d;
  endfunction

  initial begin
    bit pulse_seen;
    bit back;
    string nm;

    // Reset state, checked during and after reset
    #2;
    check("in_reset", observed(), expect_obs(1'b1, 2'd0, 6'd0, 24'h0));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 24'h123456);
      $sformat(nm, "idle_run%0d", c);
      check(nm, observed(), expect_obs(1'b1, 2'd0, 6'd0, 24'h0));
    end

    // Edit/commit table: 12:34:56 -> 15:35:56, wraps, sanitising, mode+inc
    vadd(1,0,24'h123456, 0,1,6'h00,24'h000000);
    vadd(0,1,24'h999999, 0,1,6'h00,24'h000000);
    vadd(0,1,24'h999999, 0,1,6'h00,24'h000000);
    vadd(0,1,24'h999999, 0,1,6'h00,24'h000000);
    vadd(1,0,24'h999999, 0,2,6'h00,24'h000000);
    vadd(0,1,24'h999999, 0,2,6'h00,24'h000000);
    vadd(1,0,24'h999999, 0,3,6'h00,24'h000000);
    vadd(1,0,24'h999999, 0,0,6'h3F,24'h153556);
    vadd(1,1,24'h999999, 1,0,6'h00,24'h153556);
    vadd(0,0,24'h235909, 1,0,6'h00,24'h153556);
    vadd(1,0,24'h235909, 0,1,6'h00,24'h153556);
    vadd(0,1,24'h235909, 0,1,6'h00,24'h153556);
    vadd(1,0,24'h235909, 0,2,6'h00,24'h153556);
    vadd(1,0,24'h235909, 0,3,6'h00,24'h153556);
    vadd(1,0,24'h235909, 0,0,6'h3F,24'h005909);
    vadd(0,0,24'h235909, 1,0,6'h00,24'h005909);
    vadd(1,0,24'h235909, 0,1,6'h00,24'h005909);
    vadd(1,0,24'h235909, 0,2,6'h00,24'h005909);
    vadd(0,1,24'h235909, 0,2,6'h00,24'h005909);
    vadd(1,0,24'h235909, 0,3,6'h00,24'h005909);
    vadd(1,0,24'h235909, 0,0,6'h3F,24'h230009);
    vadd(0,0,24'h235909, 1,0,6'h00,24'h230009);
    vadd(1,0,24'h235909, 0,1,6'h00,24'h230009);
    vadd(1,0,24'h235909, 0,2,6'h00,24'h230009);
    vadd(1,0,24'h235909, 0,3,6'h00,24'h230009);
    vadd(0,1,24'h235909, 0,3,6'h00,24'h230009);
    vadd(1,0,24'h235909, 0,0,6'h3F,24'h235910);
    vadd(0,0,24'h273456, 1,0,6'h00,24'h235910);
    vadd(1,0,24'h273456, 0,1,6'h00,24'h235910);
    vadd(1,1,24'h273456, 0,2,6'h00,24'h235910);
    vadd(1,0,24'h273456, 0,3,6'h00,24'h235910);
    vadd(1,0,24'h273456, 0,0,6'h3F,24'h003456);
    vadd(0,0,24'h125A56, 1,0,6'h00,24'h003456);
    vadd(1,0,24'h125A56, 0,1,6'h00,24'h003456);
    vadd(0,1,24'h125A56, 0,1,6'h00,24'h003456);
    vadd(1,0,24'h125A56, 0,2,6'h00,24'h003456);
    vadd(1,0,24'h125A56, 0,3,6'h00,24'h003456);
    vadd(1,0,24'h125A56, 0,0,6'h3F,24'h130056);
    vadd(0,0,24'h125A56, 1,0,6'h00,24'h130056);
    foreach (vecs[k]) begin
      step(vecs[k].m, vecs[k].i, vecs[k].d);
      $sformat(nm, "vec%0d", k);
      check(nm, observed(), expect_obs(vecs[k].r, vecs[k].f, vecs[k].p, vecs[k].sv));
    end

    // Idle timeout in EDIT_HR: abandon without load, counting resumes
    step(1'b1, 1'b0, 24'h123456);
    check("tmo_enter", observed(), expect_obs(1'b0, 2'd1, 6'd0, 24'h130056));
    step(1'b0, 1'b1, 24'h123456);
    pulse_seen = 1'b0;
    for (int c = 0; c < TMO - 2; c++) begin
      step(1'b0, 1'b0, 24'h123456);
      if (set_pulse != 6'd0) pulse_seen = 1'b1;
    end
    check("tmo_still_edit", 64'(field_sel), 64'(2'd1));
    back = 1'b0;
    for (int c = 0; c < 6 && !back; c++) begin
      step(1'b0, 1'b0, 24'h123456);
      if (set_pulse != 6'd0) pulse_seen = 1'b1;
      if (run_en) back = 1'b1;
    end
    if (!back) $display("FAIL tmo_wait: no return to RUN within budget");
    check("tmo_back_run", observed(), expect_obs(1'b1, 2'd0, 6'd0, 24'h130056));
    check("tmo_no_pulse", 64'(pulse_seen), 64'(1'b0));

    // Reset in EDIT_MIN, then a fresh edit loads newly captured digits
    step(1'b1, 1'b0, 24'h010203);
    step(1'b1, 1'b0, 24'h010203);
    step(1'b0, 1'b1, 24'h010203);
    check("pre_reset_min", 64'(field_sel), 64'(2'd2));
    reset = 1'b1;
    #1;
    check("async_reset", observed(), expect_obs(1'b1, 2'd0, 6'd0, 24'h0));
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 1'b0, 24'h040506);
    step(1'b1, 1'b0, 24'h040506);
    step(1'b1, 1'b0, 24'h040506);
    step(1'b1, 1'b0, 24'h040506);
    check("post_reset_commit", observed(), expect_obs(1'b0, 2'd0, 6'h3F, 24'h040506));
    step(1'b0, 1'b0, 24'h040506);
    check("post_reset_run", observed(), expect_obs(1'b1, 2'd0, 6'd0, 24'h040506));

    // Random buttons and digits against the field-level model
    ph = 0; idle = 0; m_hr = 0; m_min = 0; m_sec = 0; m_sv = 24'h040506;
    for (int c = 0; c < 3000; c++) begin
      logic        m, i;
      logic [23:0] d;
      logic [1:0]  ef;
      bit          quiet;
      quiet = (c % 300) >= 255;
      m = !quiet && ($urandom_range(0, 7) == 0);
      i = !quiet && ($urandom_range(0, 2) == 0);
      d = rand_digits();
      model_step(m, i, d);
      step(m, i, d);
      ef = (ph >= 1 && ph <= 3) ? 2'(ph) : 2'd0;
      $sformat(nm, "rand%0d", c);
      check(nm, observed(), expect_obs(ph == 0, ef, (ph == 4) ? 6'h3F : 6'h00, m_sv));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
